// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op encoding and
// small decode helpers used by the sequencer and its return stack.
package pc_seq_pkg;

  localparam int unsigned OpWidth = 3;

  localparam logic [OpWidth-1:0] OP_HOLD   = 3'b000;
  localparam logic [OpWidth-1:0] OP_INC    = 3'b001;
  localparam logic [OpWidth-1:0] OP_JUMP   = 3'b010;
  localparam logic [OpWidth-1:0] OP_BRANCH = 3'b011;
  localparam logic [OpWidth-1:0] OP_CALL   = 3'b100;
  localparam logic [OpWidth-1:0] OP_RET    = 3'b101;
  localparam logic [OpWidth-1:0] OP_CLRERR = 3'b110;
  localparam logic [OpWidth-1:0] OP_RSVD   = 3'b111;

  typedef enum logic [OpWidth-1:0] {
    OpHold   = OP_HOLD,
    OpInc    = OP_INC,
    OpJump   = OP_JUMP,
    OpBranch = OP_BRANCH,
    OpCall   = OP_CALL,
    OpRet    = OP_RET,
    OpClrErr = OP_CLRERR,
    OpRsvd   = OP_RSVD
  } pc_op_t;

  // Only CALL and RET may ever touch the return stack.
  function automatic logic is_stack_op(input logic [OpWidth-1:0] op);
    return (op == OP_CALL) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: registered depth counter with async reset, storage
// entries left unreset since only entries below the depth are ever read.
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PtrW-1:0]  depth_q, depth_d;
  logic [WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [PtrW-1:0]  top_ptr;
  logic [IdxW-1:0]  top_idx, wr_idx;
  logic             do_push, do_pop;

  assign full    = (depth_q == PtrW'(STACK_DEPTH));
  assign empty   = (depth_q == '0);
  assign top_ptr = depth_q - PtrW'(1);
  assign top_idx = IdxW'(top_ptr);
  assign wr_idx  = IdxW'(depth_q);

  // Guard against misuse; a push never overwrites and a pop never underflows.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  always_comb begin
    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + PtrW'(1);
    end else if (do_pop) begin
      depth_d = depth_q - PtrW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= din;
    end
  end

  assign dout = empty ? '0 : mem_q[top_idx];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: HOLD/INC/JUMP/BRANCH/CALL/RET/CLRERR with a
// return-address stack, sticky stack error flag and a tristate PC bus.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     WIDTH       = 16,
  parameter int unsigned     STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] target,
  input  logic             oTriEn,
  output tri   [WIDTH-1:0] PC_out,
  output logic [WIDTH-1:0] pc_q,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  pc_op_t           op_e;
  logic [WIDTH-1:0] pc_inc, pc_branch, ret_addr;
  logic             push, pop;

  assign op_e = pc_op_t'(op);

  assign pc_inc    = pc_q + WIDTH'(1);
  // Same-width add already wraps modulo 2^WIDTH, matching a sign-extended offset.
  assign pc_branch = pc_q + target;

  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    if (is_stack_op(op)) begin
      push = (op_e == OpCall) && !stack_full;
      pop  = (op_e == OpRet) && !stack_empty;
    end
  end

  pc_ret_stack #(
    .WIDTH      (WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ret_stack (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (pc_inc),
    .dout (ret_addr),
    .full (stack_full),
    .empty(stack_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_ADDR;
      stack_err <= 1'b0;
    end else begin
      case (op_e)
        OpInc:    pc_q <= pc_inc;
        OpJump:   pc_q <= target;
        OpBranch: pc_q <= pc_branch;
        OpCall: begin
          if (stack_full) begin
            stack_err <= 1'b1;
          end else begin
            pc_q <= target;
          end
        end
        OpRet: begin
          if (stack_empty) begin
            stack_err <= 1'b1;
          end else begin
            pc_q <= ret_addr;
          end
        end
        OpClrErr: stack_err <= 1'b0;
        default:  ;
      endcase
    end
  end

  assign PC_out = oTriEn ? pc_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for single-cycle ops plus
// hand sequences for async reset and the combinational bus enable.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int unsigned W = 16;
  localparam logic [W-1:0] BusPattern = 16'hA5C3;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   op;
  logic [W-1:0] target;
  logic         oTriEn;
  tri   [W-1:0] PC_out;
  logic [W-1:0] pc_q;
  logic         stack_full, stack_empty, stack_err;

  int checks = 0;
  int errors = 0;

  // Bench drives a known pattern whenever the DUT should have released the bus.
  assign PC_out = oTriEn ? {W{1'bz}} : BusPattern;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH      (W),
    .STACK_DEPTH(4),
    .RESET_ADDR (16'h0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .target     (target),
    .oTriEn     (oTriEn),
    .PC_out     (PC_out),
    .pc_q       (pc_q),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] target;
    logic         oten;
    logic [W-1:0] pc;
    logic         full;
    logic         empty;
    logic         err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input logic [W-1:0] pc, input logic full,
                           input logic empty, input logic err);
    chk({tag, " pc_q"}, 32'(pc_q), 32'(pc));
    chk({tag, " full"}, 32'(stack_full), 32'(full));
    chk({tag, " empty"}, 32'(stack_empty), 32'(empty));
    chk({tag, " err"}, 32'(stack_err), 32'(err));
    if (oTriEn) chk({tag, " PC_out"}, 32'(PC_out), 32'(pc));
    else        chk({tag, " PC_out released"}, 32'(PC_out), 32'(BusPattern));
  endtask

  task automatic step(input logic [2:0] o, input logic [W-1:0] t, input logic en);
    op     = o;
    target = t;
    oTriEn = en;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [2:0] o, input logic [W-1:0] t, input logic en,
                     input logic [W-1:0] pc, input logic f, input logic e, input logic r);
    vec_t v;
    v.op = o; v.target = t; v.oten = en; v.pc = pc; v.full = f; v.empty = e; v.err = r;
    vecs.push_back(v);
  endtask

  initial begin
    // Stack pushes PC+1 of each caller: 0011, 0101, 0201, 0301.
    add(OP_INC,    16'h0000, 1, 16'h0001, 0, 1, 0);
    add(OP_INC,    16'h0000, 1, 16'h0002, 0, 1, 0);
    add(OP_INC,    16'h0000, 1, 16'h0003, 0, 1, 0);
    add(OP_HOLD,   16'h0000, 0, 16'h0003, 0, 1, 0);
    add(OP_JUMP,   16'hFFFF, 1, 16'hFFFF, 0, 1, 0);
    add(OP_INC,    16'h0000, 1, 16'h0000, 0, 1, 0);
    add(OP_JUMP,   16'h0010, 1, 16'h0010, 0, 1, 0);
    add(OP_BRANCH, 16'hFFFE, 1, 16'h000E, 0, 1, 0);
    add(OP_BRANCH, 16'h0005, 1, 16'h0013, 0, 1, 0);
    add(OP_JUMP,   16'h0010, 1, 16'h0010, 0, 1, 0);
    add(OP_CALL,   16'h0100, 1, 16'h0100, 0, 0, 0);
    add(OP_CALL,   16'h0200, 0, 16'h0200, 0, 0, 0);
    add(OP_CALL,   16'h0300, 1, 16'h0300, 0, 0, 0);
    add(OP_CALL,   16'h0400, 1, 16'h0400, 1, 0, 0);
    add(OP_CALL,   16'h0500, 1, 16'h0400, 1, 0, 1);
    add(OP_RSVD,   16'h1234, 1, 16'h0400, 1, 0, 1);
    add(OP_INC,    16'h0000, 1, 16'h0401, 1, 0, 1);
    add(OP_RET,    16'h0000, 1, 16'h0301, 0, 0, 1);
    add(OP_RET,    16'h0000, 1, 16'h0201, 0, 0, 1);
    add(OP_RET,    16'h0000, 0, 16'h0101, 0, 0, 1);
    add(OP_RET,    16'h0000, 1, 16'h0011, 0, 1, 1);
    add(OP_CLRERR, 16'h0000, 1, 16'h0011, 0, 1, 0);
    add(OP_JUMP,   16'h0050, 1, 16'h0050, 0, 1, 0);
    add(OP_RET,    16'h0000, 1, 16'h0050, 0, 1, 1);
    add(OP_HOLD,   16'h0000, 1, 16'h0050, 0, 1, 1);
    add(OP_CLRERR, 16'h0000, 1, 16'h0050, 0, 1, 0);

    reset  = 1'b1;
    op     = OP_INC;
    target = '0;
    oTriEn = 1'b1;
    // Reset holds state even with INC presented across clock edges.
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 16'h0000, 0, 1, 0);
    op = OP_HOLD;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_state("post-reset hold", 16'h0000, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].op, vecs[i].target, vecs[i].oten);
      chk_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].full, vecs[i].empty, vecs[i].err);
    end

    // Bus enable is combinational: toggle with no clock edge in between.
    oTriEn = 1'b0;
    #1;
    chk("tri off", 32'(PC_out), 32'(BusPattern));
    chk("tri off pc_q", 32'(pc_q), 32'h0050);
    oTriEn = 1'b1;
    #1;
    chk("tri on", 32'(PC_out), 32'h0050);

    // Async reset between CALL and RET discards the stack.
    step(OP_JUMP, 16'h0010, 1);
    step(OP_CALL, 16'h0200, 1);
    chk_state("call before reset", 16'h0200, 0, 0, 0);
    op = OP_HOLD;
    #2;
    reset = 1'b1;
    #1;
    chk_state("async reset", 16'h0000, 0, 1, 0);
    #1;
    reset = 1'b0;
    step(OP_RET, 16'h0000, 1);
    chk_state("ret after reset", 16'h0000, 0, 1, 1);
    step(OP_INC, 16'h0000, 1);
    chk_state("inc keeps err", 16'h0001, 0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
